// File: rtl/sram_resp_model.sv
// sram_resp_model: behavioural single-port SRAM with bit-masked writes, post-reset clear,
// saturating access counters and a sticky protocol-error flag.
module sram_resp_model #(
    parameter int DEPTH          = 512,
    parameter int WIDTH          = 8,
    parameter int CNT_W          = 16,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cen_i,
    input  logic             gwen_i,
    input  logic [WIDTH-1:0] wen_i,
    input  logic [8:0]       a_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o,
    output logic             ready_o,
    output logic [CNT_W-1:0] rd_cnt_o,
    output logic [CNT_W-1:0] wr_cnt_o,
    output logic             err_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {INIT, READY} state_t;
    localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? INIT : READY;

    state_t           state, state_d;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    clr_ptr, idx, mem_wa;
    logic [WIDTH-1:0] mem_wd;
    logic             in_range, acc, rd_acc, wr_acc, err_d, clr_last, mem_we;

    assign idx      = a_i[AW-1:0];
    assign in_range = 32'(a_i) < DEPTH;
    assign acc      = (state == READY) && !cen_i && in_range;
    assign rd_acc   = acc && gwen_i;
    assign wr_acc   = acc && !gwen_i;
    assign err_d    = !cen_i && ((state == INIT) || !in_range);
    assign clr_last = 32'(clr_ptr) == DEPTH - 1;
    assign ready_o  = (state == READY);

    // The single write port is shared between the INIT sweep and user writes.
    always_comb begin
        state_d = state;
        mem_we  = wr_acc;
        mem_wa  = idx;
        mem_wd  = (mem[idx] & wen_i) | (d_i & ~wen_i);
        if (state == INIT) begin
            mem_we  = 1'b1;
            mem_wa  = clr_ptr;
            mem_wd  = '0;
            state_d = clr_last ? READY : INIT;
        end
    end

    always_ff @(posedge clk_i)
        if (mem_we) mem[mem_wa] <= mem_wd;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= RST_STATE;
            clr_ptr  <= '0;
            q_o      <= '0;
            rd_cnt_o <= '0;
            wr_cnt_o <= '0;
            err_o    <= 1'b0;
        end else begin
            state <= state_d;
            if (state == INIT && !clr_last) clr_ptr <= clr_ptr + AW'(1);
            if (rd_acc) q_o <= mem[idx];
            if (rd_acc && rd_cnt_o != '1) rd_cnt_o <= rd_cnt_o + CNT_W'(1);
            if (wr_acc && wr_cnt_o != '1) wr_cnt_o <= wr_cnt_o + CNT_W'(1);
            if (err_d) err_o <= 1'b1;
        end
    end
endmodule

// File: doc/sram_resp_model.md
SRAM_RESP_MODEL -- requirements
Module: sram_resp_model

Interface
REQ-001 The parameters SHALL be, one per line:
- DEPTH, 512, number of words.
- WIDTH, 8, bits per word.
- CNT_W, 16, access-counter width.
- CLEAR_ON_RESET, 1, zero the whole array after reset.
REQ-002 The ports SHALL be, one per line:
- clk_i  input  1  the single clock.
- rst_ni  input  1  asynchronous active-low reset.
- cen_i  input  1  chip enable, active-low.
- gwen_i  input  1  global write enable: 0 = write, 1 = read.
- wen_i  input  WIDTH  per-bit write mask, active-low; bit n = 0 updates data bit n.
- a_i  input  9  word address.
- d_i  input  WIDTH  write data.
- q_o  output  WIDTH  registered read data.
- ready_o  output  1  array initialised and accepting accesses.
- rd_cnt_o  output  CNT_W  accepted-read count.
- wr_cnt_o  output  CNT_W  accepted-write count.
- err_o  output  1  sticky protocol-error flag.
REQ-003 There SHALL be exactly one clock, clk_i; reset SHALL be rst_ni, asynchronous assert, active-low.
REQ-004 VDD/VSS power pins SHALL NOT be modelled.

Function
REQ-005 The FSM SHALL have two states:
- INIT: clears the array.
- READY: serves accesses.
- Leaving reset: INIT when CLEAR_ON_RESET=1, READY when CLEAR_ON_RESET=0.
REQ-006 INIT behaviour:
- Writes 0 to word clr_ptr each cycle, with clr_ptr counting 0 to DEPTH-1.
- After the cycle that writes DEPTH-1, moves to READY.
- ready_o SHALL be 1 exactly DEPTH cycles after the first clk_i edge following reset deassertion.
REQ-007 ready_o SHALL equal (state == READY).
REQ-008 Accepted access, in READY:
- Requires cen_i=0 at a rising clk_i edge with a_i < DEPTH.
- Any other condition is not an accepted access.
REQ-009 Accepted write (gwen_i=0) SHALL set mem[a_i] = (mem[a_i] & wen_i) | (d_i & ~wen_i), where unmasked bits keep their old value.
REQ-010 On an accepted write, q_o SHALL hold its previous value.
REQ-011 Accepted read (gwen_i=1) SHALL load q_o with mem[a_i] at that edge, giving a latency of 1 cycle.
REQ-012 A read on the cycle after a write to the same address SHALL return the newly written data.
REQ-013 cen_i=1 SHALL leave memory, q_o and the counters unchanged; internal state is retained while disabled.
REQ-014 A write with wen_i all-ones SHALL count as a write and leave memory unchanged.
REQ-015 Counter behaviour:
- rd_cnt_o increments by 1 per accepted read.
- wr_cnt_o increments by 1 per accepted write.
- Both saturate at 2^CNT_W-1 and never wrap.
REQ-016 err_o SHALL set (sticky until reset) on either of:
- cen_i=0 during INIT; the access is ignored and not counted.
- cen_i=0 with a_i >= DEPTH; the access is ignored, not counted, and q_o holds.
REQ-017 A legal access on the same cycle as an error condition is not possible, because one access is presented per cycle; an err_o-setting access SHALL have no other effect.
REQ-018 DEPTH SHALL be at most 512; WIDTH SHALL be at least 1.

Reset
REQ-019 Asserting rst_ni SHALL immediately force:
- q_o=0, rd_cnt_o=0, wr_cnt_o=0, err_o=0, clr_ptr=0.
- state INIT (CLEAR_ON_RESET=1) or READY (CLEAR_ON_RESET=0).
REQ-020 Array contents SHALL NOT be reset directly. Only INIT clears them; with CLEAR_ON_RESET=0, contents survive reset.
REQ-021 Reset asserted mid-INIT SHALL restart INIT from clr_ptr=0 after release.

Verification
REQ-022 Init: release reset, hold cen_i=1 -> ready_o=0 for 512 cycles, then 1; reading any address (e.g. 0x1FF) -> q_o=0x00 one cycle later.
REQ-023 Masked write: write 0xFF to 0x010 with wen_i=0x00, then 0x00 with wen_i=0x0F -> read 0x010 returns 0x0F; wr_cnt_o=2, rd_cnt_o=1.
REQ-024 Latency/hold: write 0xA5 to 0x003; next cycle read 0x003 -> q_o=0xA5 after 1 edge. Then cen_i=1 for 5 cycles -> q_o stays 0xA5 and counters stay unchanged.
REQ-025 Errors: cen_i=0 at cycle 10 of INIT -> err_o=1, counters 0; with DEPTH=256, access a_i=0x100 -> err_o=1, q_o unchanged.
REQ-026 Saturation/reset: CNT_W=4, 20 reads -> rd_cnt_o=15. Assert rst_ni mid-INIT at cycle 100 -> all outputs 0, and ready_o rises 512 cycles after release.
